butterfly_pipe: RTL and testbench
=================================

Name: butterfly_pipe

Overview:
- Parametrised, elastic successor to the dual-lane Kyber butterfly.
- Processes LANES independent coefficient pairs per beat, modulo Q, in one of four modes:
  - Cooley-Tukey (NTT)
  - Gentleman-Sande with halving (INTT)
  - plain add/sub
  - pointwise multiply
- Replaces the fixed-schedule flag inputs with a valid/ready handshake and per-beat mode/tag sideband.
- Sits between the polynomial RAM read port and the write-back port of the NTT controller.

Parameters:
- LANES, 2, number of parallel butterflies per beat
- W, 12, coefficient width in bits
- Q, 3329, modulus (odd, Q < 2^W)
- LAT, 6, accept-to-output latency in cycles with no back-pressure (minimum 4)
- TAG_W, 8, sideband tag width carried alongside each beat

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_mode  in  2  00 CT, 01 GS, 10 ADDSUB, 11 MUL
- in_a  in  LANES*W  operand a, lane i at bits [i*W +: W]
- in_b  in  LANES*W  operand b
- in_tw  in  LANES*W  twiddle / multiplier per lane
- in_tag  in  TAG_W  opaque sideband
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out0  out  LANES*W  first result per lane
- out1  out  LANES*W  second result per lane
- out_tag  out  TAG_W  tag of the beat on out0/out1
- out_mode  out  2  mode of the beat on out0/out1
- range_err  out  1  sticky: an accepted operand was >= Q
- clr_err  in  1  clears range_err

Behaviour:
- Handshake and ordering:
  - Beat accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - Beats leave in order, with their own tag and mode.
  - Mode may change every beat; no drain is needed between modes.
- Pipeline and stalls:
  - Pipeline is LAT stages with a valid bit per stage.
  - Stall condition: out_valid && !out_ready. While stalled, every stage, including out0/out1/out_tag/out_mode, holds its value.
  - in_ready = !rst && (out_ready || !out_valid), combinational.
  - No beat is dropped or duplicated under any out_ready pattern.
  - Bubbles (in_valid=0) propagate as invalid stages and do not stall.
- Latency: with out_ready held 1, a beat accepted at cycle t appears with out_valid=1 at cycle t+LAT. Throughput is 1 beat/cycle.
- Arithmetic, per lane, all modulo Q. Outputs are always canonical in [0, Q-1]:
  - CT: out0 = a + b*tw; out1 = a - b*tw.
  - GS: out0 = (a + b) * 2^-1; out1 = (a - b) * tw * 2^-1. Here 2^-1 = (Q+1)/2. Halving is done as: if even, shift; if odd, (x+Q)>>1.
  - ADDSUB: out0 = a + b; out1 = a - b. tw is ignored.
  - MUL: out0 = a * tw; out1 = b, passed through unchanged.
  - Modular reduction method is free (Barrett or Montgomery), but the result must be the exact standard residue, with no Montgomery scaling visible.
  - Intermediate products are 2W bits; no truncation before reduction.
- Range check:
  - On accept, if any lane of a or b is >= Q, range_err goes to 1 on the next cycle and stays set.
  - Affected outputs are unspecified but still in [0, 2^W-1]; flow is unaffected.
  - clr_err=1 clears range_err next cycle. If clr_err and a new error occur in the same cycle, the new error wins (range_err=1).
- Reset:
  - While rst=1: all stage valid bits cleared, out_valid=0, out0=out1=0, out_tag=0, out_mode=0, range_err=0, in_ready=0.
  - Reset mid-operation discards all in-flight beats; no output beat appears afterwards for them.
  - in_ready returns to 1 the first cycle after rst deasserts.

Test Plan:
1. CT, Q=3329, lane0 a=5, b=7, tw=17, out_ready=1 -> after exactly LAT cycles out0=124, out1=3215, tag echoed.
2. GS, lane0 a=10, b=4, tw=2 -> out0=7, out1=6. Lane1 a=3, b=0, tw=1 -> out0=1666, out1=1666.
3. ADDSUB wrap: a=3328, b=1 -> out0=0, out1=3327. MUL: a=3328, b=42, tw=3328 -> out0=1, out1=42. Issue all four modes back-to-back with tags 0..3 -> outputs in order, out_mode matching.
4. Back-pressure:
   - Stream 20 beats with tags 0..19.
   - Hold out_ready=0 for 5 cycles once out_valid=1 -> outputs frozen and in_ready=0 throughout.
   - Release -> all 20 tags arrive in order, none lost or duplicated.
   - Also run random out_ready and in_valid and compare against a reference model.
5. Range error: accept a beat with a=3329 -> range_err=1 the next cycle and held. Pulse clr_err -> cleared. clr_err asserted in the same cycle as a new bad accept -> range_err stays 1.
6. Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and all outputs 0 during reset, in_ready=1 the next cycle, and no stale beat ever appears.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Elastic multi-lane modular butterfly: CT / GS / ADDSUB / MUL, valid-ready in and out.
module butterfly_pipe #(
  parameter int unsigned LANES = 2,
  parameter int unsigned W     = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned LAT   = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*W-1:0]   in_tw,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out0,
  output logic [LANES*W-1:0]   out1,
  output logic [TAG_W-1:0]     out_tag,
  output logic [1:0]           out_mode,
  output logic                 range_err,
  input  logic                 clr_err
);

  localparam int unsigned DW   = LANES * W;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned BW   = 4 * W;
  localparam int unsigned NRES = LAT - 3;
  // Barrett constant floor(2^(2W)/Q); quotient estimate is at most one short.
  localparam logic [BW-1:0] BM = BW'((64'd1 << PW) / 64'(Q));

  localparam logic [1:0] MODE_CT  = 2'd0;
  localparam logic [1:0] MODE_GS  = 2'd1;
  localparam logic [1:0] MODE_ADD = 2'd2;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = (W+1)'(x) + (W+1)'(y);
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x >= y) return x - y;
    return W'((W+1)'(x) + (W+1)'(Q) - (W+1)'(y));
  endfunction

  // Multiply by 2^-1 mod Q: odd values borrow one Q so the shift is exact.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? (W+1)'(x) + (W+1)'(Q) : (W+1)'(x);
    return W'(s >> 1);
  endfunction

  function automatic logic [W-1:0] red_mod(input logic [PW-1:0] p);
    logic [BW-1:0] pm;
    logic [PW-1:0] qe;
    logic [PW-1:0] r;
    pm = BW'(p) * BM;
    qe = PW'(pm >> PW);
    r  = p - qe * PW'(Q);
    if (r >= PW'(Q)) r = r - PW'(Q);
    return W'(r);
  endfunction

  logic adv_c;
  logic accept_c;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [1:0]       mode1_q, mode1_d, mode2_q, mode2_d, mode3_q, mode3_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [DW-1:0]    a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [DW-1:0]    b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
  logic [DW-1:0]    tw1_q, tw1_d;
  logic [LANES*PW-1:0] p2_q, p2_d;
  logic [DW-1:0]    t3_q, t3_d;

  logic             res_v_q    [NRES];
  logic             res_v_d    [NRES];
  logic [DW-1:0]    res_o0_q   [NRES];
  logic [DW-1:0]    res_o0_d   [NRES];
  logic [DW-1:0]    res_o1_q   [NRES];
  logic [DW-1:0]    res_o1_d   [NRES];
  logic [TAG_W-1:0] res_tag_q  [NRES];
  logic [TAG_W-1:0] res_tag_d  [NRES];
  logic [1:0]       res_mode_q [NRES];
  logic [1:0]       res_mode_d [NRES];

  logic range_err_q, range_err_d;
  logic bad_c;

  assign adv_c     = !(out_valid && !out_ready);
  assign in_ready  = !rst && adv_c;
  assign accept_c  = in_valid && in_ready;

  assign out_valid = res_v_q[NRES-1];
  assign out0      = res_o0_q[NRES-1];
  assign out1      = res_o1_q[NRES-1];
  assign out_tag   = res_tag_q[NRES-1];
  assign out_mode  = res_mode_q[NRES-1];
  assign range_err = range_err_q;

  // Pipeline advance: operand select + multiply, reduce, combine, then delay to LAT.
  always_comb begin
    logic [W-1:0] x;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
    x = '0; a = '0; b = '0; t = '0;
    v1_d = v1_q; mode1_d = mode1_q; tag1_d = tag1_q; a1_d = a1_q; b1_d = b1_q; tw1_d = tw1_q;
    v2_d = v2_q; mode2_d = mode2_q; tag2_d = tag2_q; a2_d = a2_q; b2_d = b2_q; p2_d = p2_q;
    v3_d = v3_q; mode3_d = mode3_q; tag3_d = tag3_q; a3_d = a3_q; b3_d = b3_q; t3_d = t3_q;
    for (int k = 0; k < int'(NRES); k++) begin
      res_v_d[k]    = res_v_q[k];
      res_o0_d[k]   = res_o0_q[k];
      res_o1_d[k]   = res_o1_q[k];
      res_tag_d[k]  = res_tag_q[k];
      res_mode_d[k] = res_mode_q[k];
    end
    if (adv_c) begin
      v1_d = accept_c; mode1_d = in_mode; tag1_d = in_tag;
      a1_d = in_a; b1_d = in_b; tw1_d = in_tw;

      v2_d = v1_q; mode2_d = mode1_q; tag2_d = tag1_q; a2_d = a1_q; b2_d = b1_q;
      for (int i = 0; i < int'(LANES); i++) begin
        a = a1_q[i*W +: W];
        b = b1_q[i*W +: W];
        case (mode1_q)
          MODE_GS:  x = sub_mod(a, b);
          MODE_CT:  x = b;
          MODE_ADD: x = b;
          default:  x = a;
        endcase
        p2_d[i*PW +: PW] = PW'(x) * PW'(tw1_q[i*W +: W]);
      end

      v3_d = v2_q; mode3_d = mode2_q; tag3_d = tag2_q; a3_d = a2_q; b3_d = b2_q;
      for (int i = 0; i < int'(LANES); i++) begin
        t3_d[i*W +: W] = red_mod(p2_q[i*PW +: PW]);
      end

      res_v_d[0] = v3_q; res_tag_d[0] = tag3_q; res_mode_d[0] = mode3_q;
      for (int i = 0; i < int'(LANES); i++) begin
        a = a3_q[i*W +: W];
        b = b3_q[i*W +: W];
        t = t3_q[i*W +: W];
        case (mode3_q)
          MODE_CT: begin
            res_o0_d[0][i*W +: W] = add_mod(a, t);
            res_o1_d[0][i*W +: W] = sub_mod(a, t);
          end
          MODE_GS: begin
            res_o0_d[0][i*W +: W] = half_mod(add_mod(a, b));
            res_o1_d[0][i*W +: W] = half_mod(t);
          end
          MODE_ADD: begin
            res_o0_d[0][i*W +: W] = add_mod(a, b);
            res_o1_d[0][i*W +: W] = sub_mod(a, b);
          end
          default: begin
            res_o0_d[0][i*W +: W] = t;
            res_o1_d[0][i*W +: W] = b;
          end
        endcase
      end

      for (int k = 1; k < int'(NRES); k++) begin
        res_v_d[k]    = res_v_q[k-1];
        res_o0_d[k]   = res_o0_q[k-1];
        res_o1_d[k]   = res_o1_q[k-1];
        res_tag_d[k]  = res_tag_q[k-1];
        res_mode_d[k] = res_mode_q[k-1];
      end
    end
  end

  // Sticky operand range flag; a new error beats a simultaneous clear.
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (in_a[i*W +: W] >= W'(Q) || in_b[i*W +: W] >= W'(Q)) bad_c = 1'b1;
    end
    range_err_d = range_err_q;
    if (clr_err) range_err_d = 1'b0;
    if (accept_c && bad_c) range_err_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; mode1_q <= '0; tag1_q <= '0; a1_q <= '0; b1_q <= '0; tw1_q <= '0;
      v2_q <= 1'b0; mode2_q <= '0; tag2_q <= '0; a2_q <= '0; b2_q <= '0; p2_q <= '0;
      v3_q <= 1'b0; mode3_q <= '0; tag3_q <= '0; a3_q <= '0; b3_q <= '0; t3_q <= '0;
      for (int k = 0; k < int'(NRES); k++) begin
        res_v_q[k]    <= 1'b0;
        res_o0_q[k]   <= '0;
        res_o1_q[k]   <= '0;
        res_tag_q[k]  <= '0;
        res_mode_q[k] <= '0;
      end
      range_err_q <= 1'b0;
    end else begin
      v1_q <= v1_d; mode1_q <= mode1_d; tag1_q <= tag1_d; a1_q <= a1_d; b1_q <= b1_d; tw1_q <= tw1_d;
      v2_q <= v2_d; mode2_q <= mode2_d; tag2_q <= tag2_d; a2_q <= a2_d; b2_q <= b2_d; p2_q <= p2_d;
      v3_q <= v3_d; mode3_q <= mode3_d; tag3_q <= tag3_d; a3_q <= a3_d; b3_q <= b3_d; t3_q <= t3_d;
      for (int k = 0; k < int'(NRES); k++) begin
        res_v_q[k]    <= res_v_d[k];
        res_o0_q[k]   <= res_o0_d[k];
        res_o1_q[k]   <= res_o1_d[k];
        res_tag_q[k]  <= res_tag_d[k];
        res_mode_q[k] <= res_mode_d[k];
      end
      range_err_q <= range_err_d;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors, ordering, back-pressure, errors, reset.
module tb_butterfly_pipe;

  localparam int unsigned LANES = 2;
  localparam int unsigned W     = 12;
  localparam int unsigned Q     = 3329;
  localparam int unsigned LAT   = 6;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned DW    = LANES * W;
  localparam int          QI    = 3329;

  localparam logic [1:0] M_CT = 2'd0, M_GS = 2'd1, M_AS = 2'd2, M_MUL = 2'd3;

  typedef struct {
    logic [1:0]       mode;
    logic [DW-1:0]    a, b, tw;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    e0, e1;
  } vec_t;

  typedef struct {
    logic [DW-1:0]    o0, o1;
    logic [TAG_W-1:0] tag;
    logic [1:0]       mode;
  } exp_t;

  logic             clk, rst, in_valid, in_ready, out_valid, out_ready, range_err, clr_err;
  logic [1:0]       in_mode, out_mode;
  logic [DW-1:0]    in_a, in_b, in_tw, out0, out1;
  logic [TAG_W-1:0] in_tag, out_tag;

  butterfly_pipe #(.LANES(LANES), .W(W), .Q(Q), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out0(out0), .out1(out1), .out_tag(out_tag), .out_mode(out_mode),
    .range_err(range_err), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic with plain integer % and an explicit inverse of two.
  function automatic void model(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] tw, output logic [DW-1:0] o0, output logic [DW-1:0] o1);
    int inv2, x, y, z, t, r0, r1;
    inv2 = (QI + 1) / 2;
    o0 = '0; o1 = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      x = int'(a[i*W +: W]); y = int'(b[i*W +: W]); z = int'(tw[i*W +: W]);
      case (m)
        M_CT:    begin t = (y * z) % QI; r0 = (x + t) % QI; r1 = (x - t + QI) % QI; end
        M_GS:    begin r0 = (((x + y) % QI) * inv2) % QI;
                       r1 = (((((x - y + QI) % QI) * z) % QI) * inv2) % QI; end
        M_AS:    begin r0 = (x + y) % QI; r1 = (x - y + QI) % QI; end
        default: begin r0 = (x * z) % QI; r1 = y; end
      endcase
      o0[i*W +: W] = W'(r0);
      o1[i*W +: W] = W'(r1);
    end
  endfunction

  task automatic drive(input vec_t v, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_mode = v.mode; in_a = v.a; in_b = v.b; in_tw = v.tw; in_tag = tag;
  endtask

  // One isolated beat: exact latency, results, sideband, and no duplicate.
  task automatic run_vec(input int idx);
    int k;
    @(negedge clk);
    out_ready = 1'b1;
    drive(vt[idx], vt[idx].tag);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      in_valid = 1'b0;
    end while (!out_valid && k < int'(LAT) + 10);
    check($sformatf("vec%0d latency", idx), 64'(k), 64'(LAT));
    check($sformatf("vec%0d out0", idx), 64'(out0), 64'(vt[idx].e0));
    check($sformatf("vec%0d out1", idx), 64'(out1), 64'(vt[idx].e1));
    check($sformatf("vec%0d tag", idx), 64'(out_tag), 64'(vt[idx].tag));
    check($sformatf("vec%0d mode", idx), 64'(out_mode), 64'(vt[idx].mode));
    @(negedge clk);
    check($sformatf("vec%0d no_dup", idx), 64'(out_valid), 64'(0));
  endtask

  // All four modes back-to-back with tags 0..3.
  task automatic b2b;
    int n, got, first;
    n = 0; got = 0; first = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(vt[i], TAG_W'(i));
      n++;
    end
    while (got < 4 && n < 40) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        if (first < 0) first = n;
        check($sformatf("b2b%0d out0", got), 64'(out0), 64'(vt[got].e0));
        check($sformatf("b2b%0d out1", got), 64'(out1), 64'(vt[got].e1));
        check($sformatf("b2b%0d tag", got), 64'(out_tag), 64'(got));
        check($sformatf("b2b%0d mode", got), 64'(out_mode), 64'(vt[got].mode));
        got++;
      end
      n++;
    end
    check("b2b count", 64'(got), 64'(4));
    check("b2b first_latency", 64'(first), 64'(LAT));
  endtask

  // Scoreboarded stream with random valid/ready; optional 5-cycle stall at first output.
  task automatic stream(input int nbeats, input int pv, input int pr, input bit stall5);
    int   sent, got, cyc, stall_left;
    bit   acc, stall_done;
    exp_t q[$];
    exp_t e;
    sent = 0; got = 0; cyc = 0; stall_left = 0; acc = 0; stall_done = 0;
    in_valid = 1'b0;
    while ((sent < nbeats || got < sent) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin in_valid = 1'b0; acc = 0; end
      if (stall5 && !stall_done && out_valid) begin stall_left = 5; stall_done = 1; end
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < pr);
      if (!in_valid && sent < nbeats && $urandom_range(0, 99) < pv) begin
        in_valid = 1'b1;
        in_mode  = 2'($urandom_range(0, 3));
        for (int i = 0; i < int'(LANES); i++) begin
          in_a[i*W +: W]  = W'($urandom_range(0, QI - 1));
          in_b[i*W +: W]  = W'($urandom_range(0, QI - 1));
          in_tw[i*W +: W] = W'($urandom_range(0, QI - 1));
        end
        in_tag = TAG_W'(sent);
      end
      #1;
      if (stall_left > 0) begin
        check("stall in_ready", 64'(in_ready), 64'(0));
        check("stall out_valid", 64'(out_valid), 64'(1));
        if (q.size() > 0) begin
          check("stall tag", 64'(out_tag), 64'(q[0].tag));
          check("stall out0", 64'(out0), 64'(q[0].o0));
          check("stall out1", 64'(out1), 64'(q[0].o1));
        end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream spurious_beat", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          check("stream tag", 64'(out_tag), 64'(e.tag));
          check("stream mode", 64'(out_mode), 64'(e.mode));
          check("stream out0", 64'(out0), 64'(e.o0));
          check("stream out1", 64'(out1), 64'(e.o1));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        model(in_mode, in_a, in_b, in_tw, e.o0, e.o1);
        e.tag = in_tag; e.mode = in_mode;
        q.push_back(e);
        sent++;
        acc = 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream timeout", 64'(cyc < 3000), 64'(1));
    check("stream received", 64'(got), 64'(nbeats));
    check("stream leftover", 64'(q.size()), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] chk0, chk1;
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    in_mode = '0; in_a = '0; in_b = '0; in_tw = '0; in_tag = '0;

    vt[0] = '{M_CT,  {12'd100,  12'd5},    {12'd200,  12'd7},    {12'd3,    12'd17},   8'hA5,
              {12'd700,  12'd124},  {12'd2829, 12'd3215}};
    vt[1] = '{M_GS,  {12'd3,    12'd10},   {12'd0,    12'd4},    {12'd1,    12'd2},    8'h11,
              {12'd1666, 12'd7},    {12'd1666, 12'd6}};
    vt[2] = '{M_AS,  {12'd0,    12'd3328}, {12'd1,    12'd1},    {12'd5,    12'd999},  8'h22,
              {12'd1,    12'd0},    {12'd3328, 12'd3327}};
    vt[3] = '{M_MUL, {12'd2,    12'd3328}, {12'd7,    12'd42},   {12'd1665, 12'd3328}, 8'h33,
              {12'd1,    12'd1},    {12'd7,    12'd42}};
    vt[4] = '{M_CT,  {12'd3328, 12'd0},    {12'd3328, 12'd3328}, {12'd1,    12'd3328}, 8'h44,
              {12'd3327, 12'd1},    {12'd0,    12'd3328}};
    vt[5] = '{M_GS,  {12'd3328, 12'd0},    {12'd3328, 12'd1},    {12'd3328, 12'd1},    8'h55,
              {12'd3328, 12'd1665}, {12'd0,    12'd1664}};

    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(0));
    check("reset range_err", 64'(range_err), 64'(0));
    check("reset out0", 64'(out0), 64'(0));
    check("reset out1", 64'(out1), 64'(0));
    check("reset out_tag", 64'(out_tag), 64'(0));
    check("reset out_mode", 64'(out_mode), 64'(0));
    rst = 1'b0;
    #1;
    check("post_reset in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 6; i++) begin
      model(vt[i].mode, vt[i].a, vt[i].b, vt[i].tw, chk0, chk1);
      check($sformatf("table%0d model0", i), 64'(chk0), 64'(vt[i].e0));
      check($sformatf("table%0d model1", i), 64'(chk1), 64'(vt[i].e1));
      run_vec(i);
    end

    b2b();
    stream(20, 100, 100, 1'b1);
    stream(80, 70, 60, 1'b0);

    // Range error: set, hold, clear, then clear colliding with a new error.
    repeat (2) @(negedge clk);
    check("rerr idle", 64'(range_err), 64'(0));
    in_valid = 1'b1; in_mode = M_AS; in_a = {12'd0, 12'd3329}; in_b = '0; in_tw = '0; in_tag = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    check("rerr set", 64'(range_err), 64'(1));
    @(negedge clk);
    check("rerr held", 64'(range_err), 64'(1));
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("rerr cleared", 64'(range_err), 64'(0));
    in_valid = 1'b1; in_a = {12'd3328, 12'd0}; in_b = {12'd3328, 12'd0};
    @(negedge clk);
    in_valid = 1'b0;
    check("rerr good_beat", 64'(range_err), 64'(0));
    in_valid = 1'b1; in_a = '0; in_b = {12'd4095, 12'd0}; clr_err = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr_err = 1'b0;
    check("rerr clr_vs_new", 64'(range_err), 64'(1));
    repeat (LAT + 3) @(negedge clk);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      drive(vt[i], TAG_W'(8'hE0 + i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst in_ready_low", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("midrst out_valid", 64'(out_valid), 64'(0));
    check("midrst out0", 64'(out0), 64'(0));
    check("midrst out1", 64'(out1), 64'(0));
    check("midrst out_tag", 64'(out_tag), 64'(0));
    check("midrst out_mode", 64'(out_mode), 64'(0));
    check("midrst range_err", 64'(range_err), 64'(0));
    rst = 1'b0;
    #1;
    check("midrst in_ready_back", 64'(in_ready), 64'(1));
    stale = 0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst stale_beats", 64'(stale), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
